sync_fifo_ext: RTL and testbench

Parametrised single-clock FIFO, the next generation of the team's synchronous FIFO. Adds occupancy count, programmable almost-full/almost-empty thresholds, synchronous flush, a selectable first-word-fall-through (FWFT) read mode and explicit read-valid signalling. It sits between any two same-clock producer/consumer blocks and replaces the fixed-mode FIFO in new designs.

---
 rtl/sync_fifo_pkg.sv | 31 +++
 rtl/sync_fifo_mem.sv | 31 +++
 rtl/sync_fifo_ext.sv | 120 ++++++++++++
 tb/tb_sync_fifo_ext.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sync_fifo_pkg
// Brief   : Shared helpers for sync_fifo_ext: occupancy and parameter legality.
// Revision: 1.0 - initial release
// ============================================================================
package sync_fifo_pkg;

    // Pointers carry one extra wrap bit, so occupancy is a masked difference.
    function automatic int unsigned fifo_occupancy(
        input int unsigned wr_ptr,
        input int unsigned rd_ptr,
        input int unsigned ptr_bits
    );
        int unsigned mask;
        mask = (ptr_bits >= 32) ? 32'hFFFF_FFFF : ((32'd1 << ptr_bits) - 32'd1);
        return (wr_ptr - rd_ptr) & mask;
    endfunction

    function automatic bit fifo_params_ok(
        input int depth,
        input int af_level,
        input int ae_level
    );
        return (depth >= 2) && ((depth & (depth - 1)) == 0) &&
               (af_level >= 1) && (af_level <= depth) &&
               (ae_level >= 0) && (ae_level <= depth - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module  : sync_fifo_mem
// Brief   : Simple dual-port RAM, registered write port, asynchronous read.
// Revision: 1.0 - initial release
// ============================================================================
module sync_fifo_mem #(
    parameter int DEPTH      = 16,
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [WIDTH-1:0]      rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wdata;
        end
    end

    assign rdata = r_mem[rd_addr];

endmodule
`default_nettype wire

// File: rtl/sync_fifo_ext.sv
`default_nettype none
// ============================================================================
// Module  : sync_fifo_ext
// Brief   : Single-clock FIFO with count, thresholds, flush and FWFT option.
// Revision: 1.0 - initial release
// ============================================================================
module sync_fifo_ext
    import sync_fifo_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int WIDTH     = 8,
    parameter int AF_LEVEL  = DEPTH - 2,
    parameter int AE_LEVEL  = 2,
    parameter int FWFT      = 0,
    parameter int PTR_WIDTH = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 wr_en,
    input  logic [WIDTH-1:0]     wdata,
    input  logic                 rd_en,
    output logic [WIDTH-1:0]     rdata,
    output logic                 rd_valid,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic [PTR_WIDTH:0]   count,
    output logic                 wr_error,
    output logic                 rd_error
);

    localparam bit                 c_PARAMS_OK = fifo_params_ok(DEPTH, AF_LEVEL, AE_LEVEL);
    localparam logic [PTR_WIDTH:0] c_DEPTH     = (PTR_WIDTH + 1)'(DEPTH);
    localparam logic [PTR_WIDTH:0] c_AF        = (PTR_WIDTH + 1)'(AF_LEVEL);
    localparam logic [PTR_WIDTH:0] c_AE        = (PTR_WIDTH + 1)'(AE_LEVEL);

    if (!c_PARAMS_OK) begin : g_param_check
        $error("sync_fifo_ext: illegal DEPTH / AF_LEVEL / AE_LEVEL combination");
    end

    logic [PTR_WIDTH:0] r_wr_ptr;
    logic [PTR_WIDTH:0] r_rd_ptr;
    logic               r_wr_error;
    logic               r_rd_error;
    logic [WIDTH-1:0]   w_mem_rdata;
    logic               w_wr_accept;
    logic               w_rd_accept;

    assign count        = (PTR_WIDTH + 1)'(fifo_occupancy(32'(r_wr_ptr), 32'(r_rd_ptr), PTR_WIDTH + 1));
    assign full         = (count == c_DEPTH);
    assign empty        = (count == '0);
    assign almost_full  = (count >= c_AF);
    assign almost_empty = (count <= c_AE);
    assign wr_error     = r_wr_error;
    assign rd_error     = r_rd_error;

    assign w_wr_accept = wr_en && !full && !flush;
    assign w_rd_accept = rd_en && !empty && !flush;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_wr_error <= 1'b0;
            r_rd_error <= 1'b0;
        end else begin
            if (w_wr_accept) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_accept) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_wr_error <= wr_en && full;
            r_rd_error <= rd_en && empty;
        end
    end

    sync_fifo_mem #(
        .DEPTH      (DEPTH),
        .WIDTH      (WIDTH),
        .ADDR_WIDTH (PTR_WIDTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (w_wr_accept),
        .wr_addr (r_wr_ptr[PTR_WIDTH-1:0]),
        .wdata   (wdata),
        .rd_addr (r_rd_ptr[PTR_WIDTH-1:0]),
        .rdata   (w_mem_rdata)
    );

    if (FWFT != 0) begin : g_fwft
        // Head word is presented directly; zeroed while empty so reset reads as 0.
        assign rdata    = empty ? '0 : w_mem_rdata;
        assign rd_valid = !empty;
    end else begin : g_std
        logic [WIDTH-1:0] r_rdata;
        logic             r_rd_valid;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_rdata    <= '0;
                r_rd_valid <= 1'b0;
            end else if (flush) begin
                r_rd_valid <= 1'b0;
            end else begin
                r_rd_valid <= w_rd_accept;
                if (w_rd_accept) begin
                    r_rdata <= w_mem_rdata;
                end
            end
        end

        assign rdata    = r_rdata;
        assign rd_valid = r_rd_valid;
    end

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_ext.sv
`default_nettype none
// ============================================================================
// Module  : tb_sync_fifo_ext
// Brief   : Scoreboard bench driving a standard and an FWFT instance in lockstep.
// Revision: 1.0 - initial release
// ============================================================================
module tb_sync_fifo_ext;

    localparam int c_DEPTH = 16;
    localparam int c_WIDTH = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic       wr_en;
    logic       rd_en;
    logic [7:0] wdata;

    logic [7:0] rdata_s, rdata_f;
    logic       rv_s, rv_f, full_s, full_f, empty_s, empty_f;
    logic       af_s, af_f, ae_s, ae_f, werr_s, werr_f, rerr_s, rerr_f;
    logic [4:0] count_s, count_f;

    always #5 clk = ~clk;

    sync_fifo_ext #(.DEPTH(c_DEPTH), .WIDTH(c_WIDTH), .FWFT(0)) u_dut_std (
        .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wdata(wdata), .rd_en(rd_en),
        .rdata(rdata_s), .rd_valid(rv_s), .full(full_s), .empty(empty_s),
        .almost_full(af_s), .almost_empty(ae_s), .count(count_s),
        .wr_error(werr_s), .rd_error(rerr_s)
    );

    sync_fifo_ext #(.DEPTH(c_DEPTH), .WIDTH(c_WIDTH), .FWFT(1)) u_dut_fwft (
        .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wdata(wdata), .rd_en(rd_en),
        .rdata(rdata_f), .rd_valid(rv_f), .full(full_f), .empty(empty_f),
        .almost_full(af_f), .almost_empty(ae_f), .count(count_f),
        .wr_error(werr_f), .rd_error(rerr_f)
    );

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] model_q[$];
    logic [7:0] sb_q[$];
    logic [7:0] exp_last;
    logic [7:0] mon_exp;
    bit         exp_rv, exp_wr_err, exp_rd_err;
    bit         en_check = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        int sz;
        sz = model_q.size();
        check("count_std",    32'(count_s), 32'(sz));
        check("count_fwft",   32'(count_f), 32'(sz));
        check("full_std",     32'(full_s),  32'(sz == c_DEPTH));
        check("full_fwft",    32'(full_f),  32'(sz == c_DEPTH));
        check("empty_std",    32'(empty_s), 32'(sz == 0));
        check("empty_fwft",   32'(empty_f), 32'(sz == 0));
        check("afull_std",    32'(af_s),    32'(sz >= c_DEPTH - 2));
        check("aempty_std",   32'(ae_s),    32'(sz <= 2));
        check("afull_fwft",   32'(af_f),    32'(sz >= c_DEPTH - 2));
        check("aempty_fwft",  32'(ae_f),    32'(sz <= 2));
        check("wr_error_std", 32'(werr_s),  32'(exp_wr_err));
        check("rd_error_std", 32'(rerr_s),  32'(exp_rd_err));
        check("wr_error_fwft",32'(werr_f),  32'(exp_wr_err));
        check("rd_error_fwft",32'(rerr_f),  32'(exp_rd_err));
        check("rd_valid_std", 32'(rv_s),    32'(exp_rv));
        check("rdata_hold_std", 32'(rdata_s), 32'(exp_last));
        check("rd_valid_fwft",32'(rv_f),    32'(sz != 0));
        if (sz != 0) begin
            check("rdata_fwft", 32'(rdata_f), 32'(model_q[0]));
        end
    endtask

    // One clock of stimulus: check present outputs, then apply inputs and advance the model.
    task automatic step(input bit w, input bit r, input bit fl, input bit rs, input logic [7:0] d);
        bit was_full;
        bit was_empty;
        @(negedge clk);
        check_outputs();
        wr_en = w;
        rd_en = r;
        flush = fl;
        rst   = rs;
        wdata = d;
        was_full  = (model_q.size() == c_DEPTH);
        was_empty = (model_q.size() == 0);
        if (rs) begin
            model_q.delete();
            exp_rv = 1'b0; exp_last = 8'h00; exp_wr_err = 1'b0; exp_rd_err = 1'b0;
        end else if (fl) begin
            model_q.delete();
            exp_rv = 1'b0; exp_wr_err = 1'b0; exp_rd_err = 1'b0;
        end else begin
            exp_wr_err = w && was_full;
            exp_rd_err = r && was_empty;
            exp_rv     = r && !was_empty;
            if (exp_rv) begin
                exp_last = model_q.pop_front();
                sb_q.push_back(exp_last);
            end
            if (w && !was_full) begin
                model_q.push_back(d);
            end
        end
    endtask

    // Monitor: every word the standard-mode FIFO presents must match the scoreboard head.
    always @(negedge clk) begin
        if (en_check && rv_s === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL sb_unexpected_word: got rdata 0x%0h with rd_valid=1, expected no word", rdata_s);
            end else begin
                mon_exp = sb_q.pop_front();
                check("sb_rdata_std", 32'(rdata_s), 32'(mon_exp));
            end
        end
    end

    initial begin
        rst = 1'b1; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wdata = 8'h00;
        exp_rv = 1'b0; exp_last = 8'h00; exp_wr_err = 1'b0; exp_rd_err = 1'b0;
        @(posedge clk);
        en_check = 1'b1;

        step(0, 0, 0, 0, 8'h00);
        for (int i = 0; i < 16; i++) step(1, 0, 0, 0, 8'(i));
        step(1, 0, 0, 0, 8'hEE);
        step(0, 0, 0, 0, 8'h00);
        for (int i = 0; i < 16; i++) step(0, 1, 0, 0, 8'h00);
        step(0, 1, 0, 0, 8'h00);
        step(0, 0, 0, 0, 8'h00);

        for (int i = 0; i < 8; i++) step(1, 0, 0, 0, 8'($urandom));
        for (int i = 0; i < 40; i++) step(1, 1, 0, 0, 8'($urandom));
        while (model_q.size() < c_DEPTH) step(1, 0, 0, 0, 8'($urandom));
        step(1, 1, 0, 0, 8'hD1);
        step(0, 0, 0, 0, 8'h00);
        while (model_q.size() > 0) step(0, 1, 0, 0, 8'h00);
        step(1, 1, 0, 0, 8'hE2);
        step(0, 1, 0, 0, 8'h00);
        step(0, 0, 0, 0, 8'h00);

        step(1, 0, 0, 0, 8'hA5);
        step(0, 0, 0, 0, 8'h00);
        step(0, 1, 0, 0, 8'h00);
        step(0, 0, 0, 0, 8'h00);

        for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 8'($urandom));
        step(1, 1, 1, 0, 8'h77);
        step(1, 0, 0, 0, 8'h3C);
        step(0, 1, 0, 0, 8'h00);
        step(0, 0, 0, 0, 8'h00);

        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 8'($urandom));
        step(1, 1, 0, 1, 8'h55);
        step(0, 0, 0, 0, 8'h00);
        step(1, 0, 0, 0, 8'h9B);
        step(0, 1, 0, 0, 8'h00);

        for (int i = 0; i < 500; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 40) == 0), ($urandom_range(0, 80) == 0), 8'($urandom));
        end
        step(0, 0, 0, 0, 8'h00);
        step(0, 0, 0, 0, 8'h00);
        @(negedge clk);
        #1;
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
